// File: rtl/fp_stream_accumulator.sv
// Streaming IEEE-754 single-precision accumulator around a combinational add/sub unit.
// Optional: FP_ACC_FLUSH_DENORM_EN replaces exponent-0 operands by signed zero.

module fp_addsub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_res,
  output logic        o_exc
);
  logic              w_sa, w_sb, w_swap, w_sx, w_sy;
  logic [7:0]        w_ex, w_ey, w_d;
  logic [23:0]       w_mx, w_my, w_my_sh, w_norm;
  logic [24:0]       w_s;
  logic [4:0]        w_lz;
  logic signed [9:0] w_e;

  // Lowest-to-highest scan so the highest set bit wins.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  always_comb begin
    o_exc = (&i_a[30:23]) | (&i_b[30:23]);
    w_sa  = i_a[31];
    w_sb  = i_b[31] ^ i_sub;
    // Larger magnitude becomes x so the subtraction below never goes negative.
    w_swap = i_b[30:0] > i_a[30:0];
    if (w_swap) begin
      w_sx = w_sb; w_ex = i_b[30:23]; w_mx = {|i_b[30:23], i_b[22:0]};
      w_sy = w_sa; w_ey = i_a[30:23]; w_my = {|i_a[30:23], i_a[22:0]};
    end else begin
      w_sx = w_sa; w_ex = i_a[30:23]; w_mx = {|i_a[30:23], i_a[22:0]};
      w_sy = w_sb; w_ey = i_b[30:23]; w_my = {|i_b[30:23], i_b[22:0]};
    end
    w_d     = w_ex - w_ey;
    w_my_sh = w_my >> w_d;
    w_s     = (w_sx == w_sy) ? ({1'b0, w_mx} + {1'b0, w_my_sh})
                             : ({1'b0, w_mx} - {1'b0, w_my_sh});
    w_lz    = lzc24(w_s[23:0]);
    w_norm  = w_s[23:0] << w_lz;
    w_e     = $signed({2'b00, w_ex}) - $signed({5'b00000, w_lz});
    o_res   = 32'h0;
    if (o_exc)
      o_res = 32'h0;
    else if (w_s[24]) begin
      if (w_ex == 8'hFE) o_res = {w_sx, 8'hFF, 23'h0};
      else               o_res = {w_sx, w_ex + 8'd1, w_s[23:1]};
    end else if (w_s[23:0] == 24'h0)
      o_res = 32'h0;
    else if (w_e > 10'sd0)
      o_res = {w_sx, w_e[7:0], w_norm[22:0]};
  end
endmodule

module fp_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  input  logic             i_in_sub,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_sum,
  output logic [CNT_W-1:0] o_out_count,
  output logic             o_out_exception,
  output logic             o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_acc, r_out_sum;
  logic [CNT_W-1:0] r_cnt, r_out_cnt, w_cnt_nxt;
  logic             r_exc, r_out_exc;
  logic             w_accept, w_exc, w_exc_nxt;
  logic [31:0]      w_opnd, w_sum;

`ifdef FP_ACC_FLUSH_DENORM_EN
  assign w_opnd = (i_in_data[30:23] == 8'h00) ? {i_in_data[31], 31'h0} : i_in_data;
`else
  assign w_opnd = i_in_data;
`endif

  fp_addsub u_addsub (
    .i_a   (r_acc),
    .i_b   (w_opnd),
    .i_sub (i_in_sub),
    .o_res (w_sum),
    .o_exc (w_exc)
  );

  assign w_accept  = i_in_valid & o_in_ready;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_exc_nxt = r_exc | w_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM:
        if (w_accept) w_state_nxt = i_in_last ? S_DONE : S_ACCUM;
      S_DONE:
        if (i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= 32'h0;
      r_cnt     <= '0;
      r_exc     <= 1'b0;
      r_out_sum <= 32'h0;
      r_out_cnt <= '0;
      r_out_exc <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_nxt;
      r_exc <= w_exc_nxt;
      if (i_in_last) begin
        r_out_sum <= w_sum;
        r_out_cnt <= w_cnt_nxt;
        r_out_exc <= w_exc_nxt;
      end
    end else if (r_state == S_DONE && i_out_ready) begin
      r_acc <= 32'h0;
      r_cnt <= '0;
      r_exc <= 1'b0;
    end
  end

  assign o_in_ready      = (r_state != S_DONE);
  assign o_out_valid     = (r_state == S_DONE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_out_sum       = r_out_sum;
  assign o_out_count     = r_out_cnt;
  assign o_out_exception = r_out_exc;
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Randomized bench for fp_stream_accumulator against a real-arithmetic frame model.
module tb_fp_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sub, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_exc, busy;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
  logic        c2_in_ready, c2_out_valid, c2_out_exc, c2_busy;
  logic [31:0] c2_out_sum;
  logic [1:0]  c2_out_count;

  int n_chk = 0, n_err = 0;
  logic [31:0] q_op[$];
  logic        q_sub[$];
  logic [31:0] g_sum;

  always #5 clk = ~clk;

  fp_stream_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_sub(in_sub), .i_in_last(in_last),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_sum(out_sum),
    .o_out_count(out_count), .o_out_exception(out_exc), .o_busy(busy));

  fp_stream_accumulator #(.CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(c2_in_ready),
    .i_in_data(in_data), .i_in_sub(in_sub), .i_in_last(in_last),
    .o_out_valid(c2_out_valid), .i_out_ready(out_ready), .o_out_sum(c2_out_sum),
    .o_out_count(c2_out_count), .o_out_exception(c2_out_exc), .o_busy(c2_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    v = real'({1'b1, b[22:0]}) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real a;
    int  e;
    logic [22:0] m;
    if (x == 0.0) return 32'h0;
    a = (x < 0.0) ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {(x < 0.0), 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    if ($urandom_range(0, 9) == 0) return {1'($urandom), 8'hFF, 23'($urandom)};
    k = int'($urandom_range(0, 256)) - 128;
    return r2f(real'(k) / 4.0);
  endfunction

  task automatic push(input logic [31:0] d, input logic s, input logic l);
    int n = 0;
    int gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_frame(input int hold);
    real  acc = 0.0;
    logic exc = 1'b0;
    int   n = q_op.size();
    logic [31:0] es;
    for (int i = 0; i < n; i++) begin
      if (&q_op[i][30:23]) begin acc = 0.0; exc = 1'b1; end
      else acc = q_sub[i] ? acc - f2r(q_op[i]) : acc + f2r(q_op[i]);
    end
    es = r2f(acc);
    for (int i = 0; i < n; i++) push(q_op[i], q_sub[i], i == n - 1);
    g_sum = out_sum;
    chk("vld_lat", {31'h0, out_valid}, 32'h1);
    chk("busy_done", {31'h0, busy}, 32'h1);
    chk("sum", out_sum, es);
    chk("count", {24'h0, out_count}, (n > 255) ? 32'd255 : 32'(n));
    chk("exc", {31'h0, out_exc}, {31'h0, exc});
    chk("c2_count", {30'h0, c2_out_count}, (n > 3) ? 32'd3 : 32'(n));
    chk("c2_sum", c2_out_sum, es);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; in_sub = 1'($urandom);
      chk("bp_rdy", {31'h0, in_ready}, 32'h0);
      chk("bp_vld", {31'h0, out_valid}, 32'h1);
      chk("bp_sum", out_sum, es);
      chk("bp_cnt", {24'h0, out_count}, (n > 255) ? 32'd255 : 32'(n));
      chk("bp_exc", {31'h0, out_exc}, {31'h0, exc});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("vld_drop", {31'h0, out_valid}, 32'h0);
    chk("rdy_back", {31'h0, in_ready}, 32'h1);
    chk("busy_idle", {31'h0, busy}, 32'h0);
    q_op.delete(); q_sub.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, {31'h0, in_ready}, 32'h1);
    chk({tag, "_vld"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_sum"}, out_sum, 32'h0);
    chk({tag, "_cnt"}, {24'h0, out_count}, 32'h0);
    chk({tag, "_exc"}, {31'h0, out_exc}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
    in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    q_op = '{32'h3F800000, 32'h40000000, 32'h40400000}; q_sub = '{0, 0, 0};
    run_frame(0);
    chk("plan1_sum", g_sum, 32'h40C00000);

    q_op = '{32'h40400000, 32'h3FC00000}; q_sub = '{0, 1};
    run_frame(1);
    chk("plan2_sum", g_sum, 32'h3FC00000);

    q_op = '{32'h3F800000, 32'h7F800000, 32'h3F000000}; q_sub = '{0, 0, 0};
    run_frame(2);
    chk("plan3_sum", g_sum, 32'h3F000000);
    q_op = '{32'h3F800000}; q_sub = '{0};
    run_frame(0);

    q_op = '{32'h40400000}; q_sub = '{0};
    run_frame(5);

    for (int i = 0; i < 5; i++) begin q_op.push_back(32'h3F800000); q_sub.push_back(1'b0); end
    run_frame(0);
    chk("plan5_sum", g_sum, 32'h40A00000);

    q_op = '{32'h40000000}; q_sub = '{1};
    run_frame(0);
    chk("neg_single", g_sum, 32'hC0000000);

    push(32'h3F800000, 1'b0, 1'b0);
    push(32'h40000000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk) rst_n = 1'b1;
    q_op = '{32'h40000000}; q_sub = '{0};
    run_frame(0);
    chk("postrst_sum", g_sum, 32'h40000000);

    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        q_op.push_back(rand_op());
        q_sub.push_back(1'($urandom));
      end
      run_frame($urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
